// File: rtl/sawtooth_pkg.sv
// Shared definitions for the sawtooth generator / analyzer pair: freq_select
// thresholds, period classification boundaries and the analyzer state encoding.
package sawtooth_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SYNC  = 2'd1,
        S_TRACK = 2'd2
    } state_e;

    localparam int NUM_CODES = 8;

    // Generator step thresholds per freq_select code; one ramp lasts 256*(threshold+1) clocks.
    localparam int unsigned FREQ_THRESH [NUM_CODES] = '{390, 195, 130, 98, 65, 49, 32, 24};

    // Midpoints between neighbouring nominal periods, largest (code 0) first.
    localparam int unsigned PERIOD_BOUND [NUM_CODES-1] = '{75136, 41856, 29440, 21120, 14848, 10624, 7424};

    localparam int unsigned PERIOD_VALID_MIN = 3200;
    localparam int unsigned PERIOD_VALID_MAX = 200192;

endpackage

// File: rtl/sawtooth_wave_analyzer_period_classifier.sv
// Maps a measured ramp period (clk cycles) onto the nearest generator freq_select code.
module period_classifier
    import sawtooth_pkg::*;
#(
    parameter int unsigned CNT_W = 24
) (
    input  logic [CNT_W-1:0] period_i,
    output logic [2:0]       freq_code_o,
    output logic             freq_code_valid_o
);

    logic [63:0] periodWide;

    assign periodWide = 64'(period_i);

    // Walk from the smallest boundary upward so the largest satisfied bound wins.
    always_comb begin
        freq_code_o = 3'd7;
        for (int i = NUM_CODES - 2; i >= 0; i--) begin
            if (periodWide >= 64'(PERIOD_BOUND[i])) begin
                freq_code_o = 3'(i);
            end
        end
    end

    assign freq_code_valid_o = (periodWide >= 64'(PERIOD_VALID_MIN)) &&
                               (periodWide <= 64'(PERIOD_VALID_MAX));

endmodule

// File: rtl/sawtooth_wave_analyzer.sv
// Sawtooth stream analyzer: locks onto ramp wraps, measures period and peak per
// cycle, classifies the period into a freq_select code and flags loss of signal.
module sawtooth_wave_analyzer
    import sawtooth_pkg::*;
#(
    parameter int unsigned CNT_W    = 24,
    parameter int unsigned DROP_MIN = 32,
    parameter int unsigned TIMEOUT  = 250000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [7:0]       wave_in,
    output logic [CNT_W-1:0] period_out,
    output logic [7:0]       peak_out,
    output logic [2:0]       freq_code,
    output logic             freq_code_valid,
    output logic             measure_valid,
    output logic             signal_lost
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [7:0]        prev_q, prev_d;
    logic [7:0]        peakRun_q, peakRun_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [7:0]        peak_q, peak_d;
    logic [2:0]        code_q, code_d;
    logic              codeValid_q, codeValid_d;
    logic              measValid_q, measValid_d;
    logic              lost_q, lost_d;

    logic [8:0]        dropDiff;
    logic              wrap;
    logic              timeoutHit;
    logic              restart;
    logic              emit;
    logic              lose;
    logic              enterSync;
    logic [2:0]        classCode;
    logic              classValid;

    // A negative 9-bit difference is a rising sample and must never count as a wrap.
    assign dropDiff   = {1'b0, prev_q} - {1'b0, wave_in};
    assign wrap       = sample_valid && !dropDiff[8] && (dropDiff > 9'(DROP_MIN));
    assign timeoutHit = (tmo_q == TMO_W'(TIMEOUT - 1));

    period_classifier #(
        .CNT_W (CNT_W)
    ) uClassifier (
        .period_i          (cnt_q),
        .freq_code_o       (classCode),
        .freq_code_valid_o (classValid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (sample_valid) state_d = S_SYNC;
            S_SYNC:  if (wrap) state_d = S_TRACK;
            S_TRACK: if (!wrap && timeoutHit) state_d = S_SYNC;
            default: state_d = S_IDLE;
        endcase
    end

    // A wrap coinciding with a timeout is treated as a wrap.
    always_comb begin
        restart   = 1'b0;
        emit      = 1'b0;
        lose      = 1'b0;
        enterSync = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                enterSync = sample_valid;
            end
            S_SYNC: begin
                restart = wrap;
                lose    = timeoutHit && !wrap;
            end
            S_TRACK: begin
                restart = wrap;
                emit    = wrap;
                lose    = timeoutHit && !wrap;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        prev_d = sample_valid ? wave_in : prev_q;

        if (restart) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == {CNT_W{1'b1}}) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        peakRun_d = peakRun_q;
        if (restart) begin
            peakRun_d = wave_in;
        end else if (sample_valid && !wrap && (wave_in > peakRun_q)) begin
            peakRun_d = wave_in;
        end

        if (state_q == S_IDLE || restart || lose || enterSync) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        period_d    = emit ? cnt_q      : period_q;
        peak_d      = emit ? peakRun_q  : peak_q;
        code_d      = emit ? classCode  : code_q;
        codeValid_d = emit ? classValid : codeValid_q;
        measValid_d = emit;

        lost_d = lost_q;
        if (emit) begin
            lost_d = 1'b0;
        end else if (lose) begin
            lost_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q      <= '0;
            peakRun_q   <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            period_q    <= '0;
            peak_q      <= '0;
            code_q      <= '0;
            codeValid_q <= 1'b0;
            measValid_q <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            peakRun_q   <= peakRun_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            period_q    <= period_d;
            peak_q      <= peak_d;
            code_q      <= code_d;
            codeValid_q <= codeValid_d;
            measValid_q <= measValid_d;
            lost_q      <= lost_d;
        end
    end

    assign period_out      = period_q;
    assign peak_out        = peak_q;
    assign freq_code       = code_q;
    assign freq_code_valid = codeValid_q;
    assign measure_valid   = measValid_q;
    assign signal_lost     = lost_q;

endmodule

// File: tb/tb_sawtooth_wave_analyzer.sv
// Directed bench for sawtooth_wave_analyzer: classifier table, ramp measurements,
// wrap threshold, reset mid-track and loss-of-signal recovery.
`timescale 1ns/1ps
module tb_sawtooth_wave_analyzer;

    localparam int CNT_W = 24;

    logic             clk = 1'b0;
    logic             reset;
    logic             sampleValid;
    logic [7:0]       waveIn;

    logic [CNT_W-1:0] periodOut, lossPeriod;
    logic [7:0]       peakOut, lossPeak;
    logic [2:0]       freqCode, lossCode;
    logic             freqCodeValid, lossCodeValid;
    logic             measureValid, lossMeasureValid;
    logic             signalLost, lossSignalLost;

    logic [CNT_W-1:0] clsPeriod;
    logic [2:0]       clsCode;
    logic             clsValid;

    int checks = 0;
    int errors = 0;

    logic             snapLossMv;
    logic             snapLossLost;
    logic [CNT_W-1:0] snapLossPeriod;

    typedef struct {
        logic [CNT_W-1:0] period;
        logic [2:0]       code;
        logic             valid;
    } classVec_t;

    classVec_t classVecs [20];

    always #20 clk = ~clk;

    sawtooth_wave_analyzer #(
        .CNT_W    (CNT_W),
        .DROP_MIN (32),
        .TIMEOUT  (30000)
    ) dutMain (
        .clk             (clk),
        .reset           (reset),
        .sample_valid    (sampleValid),
        .wave_in         (waveIn),
        .period_out      (periodOut),
        .peak_out        (peakOut),
        .freq_code       (freqCode),
        .freq_code_valid (freqCodeValid),
        .measure_valid   (measureValid),
        .signal_lost     (signalLost)
    );

    sawtooth_wave_analyzer #(
        .CNT_W    (CNT_W),
        .DROP_MIN (32),
        .TIMEOUT  (1000)
    ) dutLoss (
        .clk             (clk),
        .reset           (reset),
        .sample_valid    (sampleValid),
        .wave_in         (waveIn),
        .period_out      (lossPeriod),
        .peak_out        (lossPeak),
        .freq_code       (lossCode),
        .freq_code_valid (lossCodeValid),
        .measure_valid   (lossMeasureValid),
        .signal_lost     (lossSignalLost)
    );

    period_classifier #(
        .CNT_W (CNT_W)
    ) uClass (
        .period_i          (clsPeriod),
        .freq_code_o       (clsCode),
        .freq_code_valid_o (clsValid)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // One ramp 0..top, each value held stepLen clocks; its first sample is the wrap
    // that closes the previous ramp, so the expected values describe that ramp.
    task automatic applyStimulus(input int top, input int stepLen, input bit doCheck,
                                 input bit expMeas, input int expPeriod, input int expPeak,
                                 input int expCode, input bit expCodeValid, input bit dips,
                                 input string tag);
        int extra;
        extra = 0;
        for (int v = 0; v <= top; v++) begin
            for (int k = 0; k < stepLen; k++) begin
                sampleValid = 1'b1;
                waveIn      = 8'(v);
                if (dips) begin
                    if (v == 100 && k == 1) waveIn = 8'd90;
                    if (v == 200 && k == 1) waveIn = 8'd168;
                    if (v == 150 && k == 2) begin
                        sampleValid = 1'b0;
                        waveIn      = 8'd0;
                    end
                end
                stepCycle();
                if (v == 0 && k == 0) begin
                    snapLossMv     = lossMeasureValid;
                    snapLossLost   = lossSignalLost;
                    snapLossPeriod = lossPeriod;
                    if (doCheck) begin
                        checkOutput($sformatf("%s measure_valid", tag), measureValid, expMeas);
                        if (expMeas) begin
                            checkOutput($sformatf("%s period", tag), periodOut, expPeriod);
                            checkOutput($sformatf("%s peak", tag), peakOut, expPeak);
                            checkOutput($sformatf("%s freq_code", tag), freqCode, expCode);
                            checkOutput($sformatf("%s freq_code_valid", tag), freqCodeValid, expCodeValid);
                        end
                    end
                end else if (measureValid) begin
                    extra++;
                end
            end
        end
        sampleValid = 1'b1;
        if (doCheck) checkOutput($sformatf("%s extra pulses", tag), extra, 0);
    endtask

    initial begin
        int lostEarly;
        int lossPulses;

        reset       = 1'b1;
        sampleValid = 1'b0;
        waveIn      = 8'd0;
        clsPeriod   = '0;

        classVecs[0]  = '{24'd0,        3'd7, 1'b0};
        classVecs[1]  = '{24'd3199,     3'd7, 1'b0};
        classVecs[2]  = '{24'd3200,     3'd7, 1'b1};
        classVecs[3]  = '{24'd7423,     3'd7, 1'b1};
        classVecs[4]  = '{24'd7424,     3'd6, 1'b1};
        classVecs[5]  = '{24'd10623,    3'd6, 1'b1};
        classVecs[6]  = '{24'd10624,    3'd5, 1'b1};
        classVecs[7]  = '{24'd14847,    3'd5, 1'b1};
        classVecs[8]  = '{24'd14848,    3'd4, 1'b1};
        classVecs[9]  = '{24'd21119,    3'd4, 1'b1};
        classVecs[10] = '{24'd21120,    3'd3, 1'b1};
        classVecs[11] = '{24'd29439,    3'd3, 1'b1};
        classVecs[12] = '{24'd29440,    3'd2, 1'b1};
        classVecs[13] = '{24'd41855,    3'd2, 1'b1};
        classVecs[14] = '{24'd41856,    3'd1, 1'b1};
        classVecs[15] = '{24'd75135,    3'd1, 1'b1};
        classVecs[16] = '{24'd75136,    3'd0, 1'b1};
        classVecs[17] = '{24'd200192,   3'd0, 1'b1};
        classVecs[18] = '{24'd200193,   3'd0, 1'b0};
        classVecs[19] = '{24'd16777215, 3'd0, 1'b0};

        for (int i = 0; i < 20; i++) begin
            clsPeriod = classVecs[i].period;
            #1;
            checkOutput($sformatf("class code P=%0d", classVecs[i].period), clsCode, classVecs[i].code);
            checkOutput($sformatf("class valid P=%0d", classVecs[i].period), clsValid, classVecs[i].valid);
        end

        repeat (3) stepCycle();
        checkOutput("reset period", periodOut, 0);
        checkOutput("reset peak", peakOut, 0);
        checkOutput("reset freq_code", freqCode, 0);
        checkOutput("reset freq_code_valid", freqCodeValid, 0);
        checkOutput("reset measure_valid", measureValid, 0);
        checkOutput("reset signal_lost", signalLost, 0);
        reset = 1'b0;

        repeat (5) stepCycle();
        checkOutput("idle measure_valid", measureValid, 0);
        checkOutput("idle signal_lost", signalLost, 0);

        sampleValid = 1'b1;
        waveIn      = 8'd255;
        repeat (4) stepCycle();

        applyStimulus(255, 3,  1, 0, 0,     0,   0, 0, 0, "lock");
        applyStimulus(255, 25, 1, 1, 768,   255, 7, 0, 0, "step3");
        applyStimulus(255, 99, 1, 1, 6400,  255, 7, 1, 0, "step25");
        applyStimulus(255, 29, 1, 1, 25344, 255, 3, 1, 0, "step99");
        applyStimulus(127, 50, 1, 1, 7424,  255, 6, 1, 0, "step29");
        applyStimulus(255, 3,  1, 1, 6400,  127, 7, 1, 0, "half");
        applyStimulus(255, 4,  1, 1, 768,   255, 7, 0, 1, "step3b");
        applyStimulus(255, 4,  1, 1, 1024,  255, 7, 0, 0, "dips");

        // 255 -> 222 is a drop of 33, just over the wrap threshold.
        waveIn = 8'd222;
        stepCycle();
        checkOutput("drop33 measure_valid", measureValid, 1);
        checkOutput("drop33 period", periodOut, 1024);
        checkOutput("drop33 peak", peakOut, 255);

        waveIn = 8'd230;
        repeat (10) stepCycle();
        #5 reset = 1'b1;
        #1;
        checkOutput("midreset period", periodOut, 0);
        checkOutput("midreset peak", peakOut, 0);
        checkOutput("midreset freq_code", freqCode, 0);
        checkOutput("midreset measure_valid", measureValid, 0);
        checkOutput("midreset signal_lost", signalLost, 0);
        stepCycle();
        reset  = 1'b0;
        waveIn = 8'd255;
        repeat (4) stepCycle();

        applyStimulus(255, 3, 1, 0, 0,   0,   0, 0, 0, "relock");
        applyStimulus(255, 3, 1, 1, 768, 255, 7, 0, 0, "afterReset");

        waveIn = 8'd0;
        stepCycle();
        checkOutput("loss lastwrap measure_valid", lossMeasureValid, 1);
        checkOutput("loss lastwrap period", lossPeriod, 768);
        checkOutput("loss lastwrap signal_lost", lossSignalLost, 0);

        lostEarly  = 0;
        lossPulses = 0;
        for (int i = 1; i < 1000; i++) begin
            stepCycle();
            if (lossSignalLost)   lostEarly++;
            if (lossMeasureValid) lossPulses++;
        end
        checkOutput("loss early assertion", lostEarly, 0);
        stepCycle();
        if (lossMeasureValid) lossPulses++;
        checkOutput("loss signal_lost at 1000", lossSignalLost, 1);
        checkOutput("loss held period", lossPeriod, 768);
        checkOutput("loss held peak", lossPeak, 255);
        checkOutput("loss held freq_code", lossCode, 7);
        checkOutput("loss no pulses", lossPulses, 0);

        repeat (100) stepCycle();
        applyStimulus(255, 3, 0, 0, 0, 0, 0, 0, 0, "resume0");
        applyStimulus(255, 3, 0, 0, 0, 0, 0, 0, 0, "resume1");
        checkOutput("resume wrap1 measure_valid", snapLossMv, 0);
        checkOutput("resume wrap1 signal_lost", snapLossLost, 1);
        applyStimulus(255, 3, 0, 0, 0, 0, 0, 0, 0, "resume2");
        checkOutput("resume wrap2 measure_valid", snapLossMv, 1);
        checkOutput("resume wrap2 signal_lost", snapLossLost, 0);
        checkOutput("resume wrap2 period", snapLossPeriod, 768);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sawtooth_wave_analyzer.md
Name: sawtooth_wave_analyzer

Overview:
Receive-side companion to the ADSR sawtooth generator: consumes an 8-bit sawtooth sample stream and measures it.
- Detects each wrap (falling reset edge) of the ramp.
- Measures the period in clk cycles and the peak amplitude per cycle.
- Classifies the period into the generator's 3-bit freq_select code.
- Flags loss of signal, e.g. envelope at zero or note released.
Sits on the generator output bus in loopback/self-test builds and in the waveform monitor path.

Parameters:
CNT_W, 24, period counter width (saturating)
DROP_MIN, 32, minimum sample-to-sample drop (prev - wave_in) that counts as a wrap; strictly greater than
TIMEOUT, 250000, clk cycles without a wrap before signal_lost asserts (10 ms at 25 MHz)

Ports:
clk  in  1  25 MHz clock
reset  in  1  asynchronous, active-high
sample_valid  in  1  wave_in is taken only when high; tie high for direct connection
wave_in  in  8  sawtooth sample (unsigned)
period_out  out  CNT_W  clk cycles between the last two wraps
peak_out  out  8  maximum sample over the last completed cycle
freq_code  out  3  nearest freq_select code for period_out
freq_code_valid  out  1  period_out within classification range
measure_valid  out  1  one-cycle pulse when the outputs update
signal_lost  out  1  level, no wrap for TIMEOUT cycles

Behaviour:
- Reset (asynchronous):
  - All outputs 0.
  - Internal registers prev=0, cnt=0, peak_run=0.
  - State S_IDLE.
  - Reset mid-operation discards the partial measurement.
- States:
  - S_IDLE: on the first valid sample, prev<=wave_in, go to S_SYNC.
  - S_SYNC: waits for the first wrap; no measurement is emitted. On wrap: cnt<=1, peak_run<=wave_in, go to S_TRACK.
  - S_TRACK: on each wrap, emit a measurement.
- Wrap detect: sample_valid && (prev - wave_in) > DROP_MIN. Use a 9-bit difference; a rise or equal sample is never a wrap. prev updates on every valid sample.
- cnt increments on every clk (not per sample) and saturates at 2^CNT_W-1. Wraps at cycles t0 and t1 give period_out = t1 - t0.
- peak_run <= max(peak_run, wave_in) on every valid non-wrap sample.
- On a wrap in S_TRACK:
  - period_out<=cnt, peak_out<=peak_run.
  - cnt<=1, peak_run<=wave_in.
  - measure_valid pulses the next cycle, one-cycle registered latency.
  - signal_lost<=0.
  - freq_code and freq_code_valid update in the same cycle as period_out.
- Timeout: in S_SYNC or S_TRACK, a cycle counter (cleared on every wrap, and on entry to S_SYNC) reaching TIMEOUT:
  - signal_lost<=1, go to S_SYNC.
  - Last period/peak/freq outputs are held; no measure_valid pulse.
  - signal_lost clears only on the next emitted measurement, i.e. the second wrap after the loss.
- Classification: period P = 256*(threshold+1).
  - P>=75136 -> 0
  - >=41856 -> 1
  - >=29440 -> 2
  - >=21120 -> 3
  - >=14848 -> 4
  - >=10624 -> 5
  - >=7424 -> 6
  - else 7
  - freq_code_valid = (P>=3200 && P<=200192); freq_code is still computed outside that range.
- Simultaneous wrap and timeout in one cycle: the wrap wins (measurement emitted, signal_lost cleared).
- sample_valid low: no wrap or peak update that cycle; cnt still counts.

Decomposition:
- Shared package sawtooth_pkg holds:
  - the freq_select threshold table (390,195,130,98,65,49,32,24), also reusable by the generator;
  - the period boundary constants (75136…7424, 3200, 200192);
  - the state encoding (S_IDLE, S_SYNC, S_TRACK).
- One sub-module, period_classifier: combinational period -> freq_code/freq_code_valid, registered in the parent.

Test Plan:
1. Ramp 0..255, one step per 391 clk, wrap to 0 -> second and later wraps give period_out=100096, peak_out=255, freq_code=0, freq_code_valid=1, measure_valid one cycle after each wrap sample.
2. Ramp step every 25 clk -> period_out=6400, freq_code=7; step every 99 clk -> 25344, freq_code=3.
3. Ramp 0..127, step every 50 clk (amplitude-scaled by the envelope) -> peak_out=127, period_out=6400, freq_code=7; DROP_MIN drop 127->0 detected.
4. Ramp with injected 10-LSB dips (drop < DROP_MIN) -> no extra wraps, period unchanged; a drop of exactly 32 -> no wrap, a drop of 33 -> wrap.
5. After lock, hold wave_in=0 (TIMEOUT=1000 in bench) -> signal_lost=1 exactly 1000 cycles after the last wrap, outputs held; resume ramp -> signal_lost clears with the second wrap's measure_valid.
6. Assert reset mid-cycle in S_TRACK -> all outputs 0 immediately; the first measurement after release appears only at the second wrap.
